state_register_serializer: RTL and testbench
============================================

Name: state_register_serializer

Overview:
- Readout side of the ASCON permutation state register: snapshots a full 320-bit type_state (x0..x4) and streams it out as 64-bit words over a valid/ready handshake.
- Sits between the state register output and the tag/ciphertext output path or a debug readout port.
- Frees the state register for the next operation as soon as the snapshot is taken.

Parameters:
- N_WORDS, 5, number of 64-bit words per state (ascon_pack type_state); fixed at 5 for ASCON, exposed for test only.
- WORD_W, 64, width of one state word.
- CNT_W, 3, width of the word index counter; must satisfy 2**CNT_W >= N_WORDS.

Ports:
- clock_i  input  1  system clock, all logic on rising edge.
- resetb_i  input  1  reset, synchronous, active-low.
- start_i  input  1  request to snapshot state_i and begin streaming; sampled only in IDLE.
- state_i  input  type_state (5x64)  state to serialize; x0 = word index 0.
- word_o  output  WORD_W  current output word.
- valid_o  output  1  word_o holds a valid word.
- ready_i  input  1  downstream accepts word_o this cycle.
- idx_o  output  CNT_W  index (0..N_WORDS-1) of the word on word_o.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- done_o  output  1  single-cycle pulse after the last word is accepted.

Behaviour:
- Reset: one clock edge with resetb_i=0 forces FSM=IDLE, snapshot=all zeros, idx=0, valid_o=0, busy_o=0, done_o=0, word_o=0. Reset is synchronous; no effect between edges. A reset mid-stream aborts the transfer: no done_o, and the partial stream is discarded.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - Outputs: valid_o=0, busy_o=0, word_o=0.
  - If start_i=1 at an edge: capture state_i into the snapshot register, idx:=0, go to SEND.
  - Else stay in IDLE.
- SEND:
  - Outputs: valid_o=1, busy_o=1, word_o=snapshot[idx], idx_o=idx.
  - The first valid word appears the cycle after start_i is sampled (latency 1).
  - Handshake: a transfer occurs on an edge where valid_o=1 and ready_i=1.
  - Transfer with idx<N_WORDS-1: idx:=idx+1, stay in SEND.
  - Transfer with idx=N_WORDS-1: idx:=0, go to DONE.
  - ready_i=0: hold idx and word_o stable. valid_o must not drop until the transfer occurs.
  - With ready_i held high, one word transfers per cycle; 5 words take 5 cycles.
- DONE:
  - Outputs: done_o=1 for exactly one cycle, valid_o=0, busy_o=1.
  - Unconditionally go to IDLE next edge.
- Start handling:
  - start_i is ignored in SEND and DONE; there is no queueing.
  - Back-to-back operation: earliest re-start is the cycle after DONE, so the minimum period is N_WORDS+2 cycles per state.
- Snapshot independence: changes on state_i after capture do not affect the stream.
- idx_o reads 0 in IDLE and DONE.
- ready_i asserted while valid_o=0 has no effect.

Test Plan:
- Reset then idle: hold resetb_i=0 for 2 cycles, release, no start -> valid_o=0, busy_o=0, done_o=0, word_o=0 for 10 cycles.
- Full-rate stream:
  - Stimulus: state_i = {x0=64'h0123456789ABCDEF, x1=64'h1111111111111111, x2=64'h2222222222222222, x3=64'h3333333333333333, x4=64'h4444444444444444}, start_i pulsed 1 cycle, ready_i=1 throughout.
  - Required: words x0..x4 on 5 consecutive cycles starting 1 cycle after start, with idx_o 0..4; done_o pulses once on the following cycle; busy_o falls the cycle after that.
- Backpressure:
  - Stimulus: same state, ready_i toggled 1,0,0,1,0,1,1,1.
  - Required: word_o and idx_o stable while ready_i=0; every word transferred exactly once, in order; done_o follows the 5th transfer.
- Snapshot and ignored start:
  - Stimulus: after capture, change state_i to all 64'hFFFFFFFFFFFFFFFF and pulse start_i during SEND.
  - Required: the original words are still streamed; only one done_o; no second stream starts.
- Reset mid-stream:
  - Stimulus: assert resetb_i=0 for one edge after 2 words are transferred.
  - Required: next cycle valid_o=0, busy_o=0, idx_o=0, word_o=0; no done_o pulse.
  - Follow-up: a new start streams a fresh state from x0.
- Back-to-back:
  - Stimulus: start_i asserted the cycle after done_o, with a new state {x0..x4 = 64'hA0..A4}.
  - Required: the second stream begins 1 cycle later; total 7 cycles per state with ready_i=1.

Source files
------------

// File: rtl/state_register_serializer.sv
// Snapshots a 320-bit ASCON permutation state (x0..x4) and streams it out
// as 64-bit words over a valid/ready handshake, x0 first.
module state_register_serializer #(
    parameter int N_WORDS = 5,
    parameter int WORD_W  = 64,
    parameter int CNT_W   = 3
) (
    input  logic                            clock_i,
    input  logic                            resetb_i,
    input  logic                            start_i,
    input  logic [N_WORDS-1:0][WORD_W-1:0]  state_i,
    output logic [WORD_W-1:0]               word_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [CNT_W-1:0]                idx_o,
    output logic                            busy_o,
    output logic                            done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [N_WORDS-1:0][WORD_W-1:0]  r_snap;
    logic [CNT_W-1:0]                r_idx;
    logic [CNT_W-1:0]                w_idx_nxt;
    logic                            w_capture;
    logic [WORD_W-1:0]               w_sel_word;

    // Explicit compare-select so index codes beyond N_WORDS-1 read as zero.
    function automatic logic [WORD_W-1:0] sel_word(
        input logic [N_WORDS-1:0][WORD_W-1:0] snap,
        input logic [CNT_W-1:0]               idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx == CNT_W'(i)) begin
                w = snap[i];
            end
        end
        return w;
    endfunction

    assign w_sel_word = sel_word(r_snap, r_idx);

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // The snapshot frees the upstream state register the moment it is taken.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= state_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        valid_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        word_o      = '0;
        idx_o       = '0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end

            ST_SEND: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                word_o  = w_sel_word;
                idx_o   = r_idx;
                if (ready_i) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                done_o      = 1'b1;
                busy_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_state_register_serializer.sv
// Scoreboard bench for state_register_serializer: stimulus pushes expected
// {idx,word} entries, a negedge monitor pops them on each handshake.
module tb_state_register_serializer;

    localparam int NW = 5;
    localparam int WW = 64;
    localparam int CW = 3;

    logic                    clk    = 1'b0;
    logic                    resetb = 1'b0;
    logic                    start  = 1'b0;
    logic                    ready  = 1'b0;
    logic [NW-1:0][WW-1:0]   st     = '0;
    logic [WW-1:0]           word;
    logic                    valid;
    logic [CW-1:0]           idx;
    logic                    busy;
    logic                    done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ndone    = 0;

    logic [CW+WW-1:0] exp_q[$];
    logic             hold = 1'b0;
    logic [CW+WW-1:0] hold_v;
    logic [CW+WW-1:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    state_register_serializer #(
        .N_WORDS (NW),
        .WORD_W  (WW),
        .CNT_W   (CW)
    ) dut (
        .clock_i  (clk),
        .resetb_i (resetb),
        .start_i  (start),
        .state_i  (st),
        .word_o   (word),
        .valid_o  (valid),
        .ready_i  (ready),
        .idx_o    (idx),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: transfers, hold stability under backpressure, done placement.
    always @(negedge clk) begin
        if (!resetb) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 72'(valid), 72'(1));
                chk("hold_word_idx", 72'({idx, word}), 72'(hold_v));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none", {idx, word});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_word", 72'({idx, word}), 72'(mon_e));
                end
            end
            if (done) begin
                ndone++;
                chk("done_after_last", 72'(exp_q.size()), 72'(0));
                chk("done_outputs", 72'({valid, busy, idx}), 72'({1'b0, 1'b1, 3'd0}));
            end
            hold   = valid && !ready;
            hold_v = {idx, word};
        end
    end

    task automatic start_stream(input logic [NW-1:0][WW-1:0] s, output int scyc);
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back({CW'(i), s[i]});
        end
        st    = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        scyc  = cyc;
        chk("first_word_latency", 72'({valid, busy, idx, word}), 72'({1'b1, 1'b1, 3'd0, s[0]}));
    endtask

    task automatic wait_done(input logic [7:0] pat, output int dcyc);
        bit got;
        got  = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 60; i++) begin
            ready = (i < 8) ? pat[i] : 1'b1;
            tick();
            if (done) begin
                dcyc = cyc;
                got  = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_60");
        end
    endtask

    initial begin
        int s1, s2, d, nd0;
        logic [NW-1:0][WW-1:0] sa, sb, sc, sf;
        sa = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222,
              64'h1111111111111111, 64'h0123456789ABCDEF};
        sb = {64'h00000000000000A4, 64'h00000000000000A3, 64'h00000000000000A2,
              64'h00000000000000A1, 64'h00000000000000A0};
        sc = {64'hB4B4B4B4B4B4B4B4, 64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2,
              64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
        sf = '1;

        // Reset, then idle with no start.
        resetb = 1'b0;
        tick();
        tick();
        resetb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_after_reset", 72'({valid, busy, done, idx, word}), 72'(0));
            tick();
        end

        // Full-rate stream.
        nd0 = ndone;
        ready = 1'b1;
        start_stream(sa, s1);
        wait_done(8'hFF, d);
        chk("full_rate_cycles", 72'(d - s1), 72'(5));
        tick();
        chk("busy_fall", 72'({busy, valid, done}), 72'(0));
        chk("full_rate_one_done", 72'(ndone - nd0), 72'(1));

        // Backpressure 1,0,0,1,0,1,1,1.
        tick();
        nd0 = ndone;
        start_stream(sa, s1);
        wait_done(8'hE9, d);
        chk("bp_cycles", 72'(d - s1), 72'(8));
        tick();
        chk("bp_one_done", 72'(ndone - nd0), 72'(1));

        // Snapshot independence and ignored start during SEND.
        tick();
        nd0 = ndone;
        start_stream(sa, s1);
        ready = 1'b0;
        st    = sf;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("snap_word_held", 72'({valid, idx, word}), 72'({1'b1, 3'd0, sa[0]}));
        wait_done(8'h00, d);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("no_second_stream", 72'({valid, busy, done}), 72'(0));
            tick();
        end
        chk("snap_one_done", 72'(ndone - nd0), 72'(1));

        // Reset after two transfers aborts the stream.
        nd0 = ndone;
        start_stream(sa, s1);
        ready = 1'b1;
        tick();
        tick();
        chk("pre_reset_idx", 72'({valid, idx}), 72'({1'b1, 3'd2}));
        ready  = 1'b0;
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        chk("reset_abort_outs", 72'({valid, busy, done, idx, word}), 72'(0));
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_no_done", 72'({valid, busy, done}), 72'(0));
        end
        chk("reset_done_count", 72'(ndone - nd0), 72'(0));
        start_stream(sc, s1);
        wait_done(8'hFF, d);
        chk("restart_cycles", 72'(d - s1), 72'(5));

        // Back-to-back: restart in the IDLE cycle right after DONE.
        tick();
        tick();
        start_stream(sa, s1);
        wait_done(8'hFF, d);
        tick();
        start_stream(sb, s2);
        chk("b2b_period", 72'(s2 - s1), 72'(7));
        wait_done(8'hFF, d);
        chk("b2b_second_cycles", 72'(d - s2), 72'(5));

        repeat (3) tick();
        chk("queue_drained", 72'(exp_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
